// File: rtl/count_scheduler.sv
// rtl/count_scheduler.sv - two-requester round-robin owner of a shared up-counter
module count_scheduler #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] len0,
    input  logic             req1,
    input  logic [WIDTH-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t           state;
    logic [WIDTH-1:0] len_q;
    logic             last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            busy  <= 1'b0;
            out   <= '0;
            len_q <= '0;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // requester 0 wins unless requester 1 also asks and 0 was served last
                    if (req0 && (!req1 || last)) begin
                        state <= RUN;
                        gnt0  <= 1'b1;
                        busy  <= 1'b1;
                        out   <= '0;
                        len_q <= len0;
                        last  <= 1'b0;
                    end else if (req1) begin
                        state <= RUN;
                        gnt1  <= 1'b1;
                        busy  <= 1'b1;
                        out   <= '0;
                        len_q <= len1;
                        last  <= 1'b1;
                    end
                end
                RUN: begin
                    if (out == len_q) begin
                        state <= GAP;
                        done0 <= gnt0;
                        done1 <= gnt1;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        out   <= '0;
                    end else begin
                        out <= out + WIDTH'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_scheduler.sv
// tb/tb_count_scheduler.sv - directed bench with schedule-queue reference model
module tb_count_scheduler;

    logic       clk = 1'b0;
    logic       rst, req0, req1;
    logic [2:0] len0, len1;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [2:0] out;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    count_scheduler #(.WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .len0(len0), .req1(req1), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .busy(busy), .out(out)
    );

    typedef struct packed {
        logic       g0, g1, d0, d1, busy;
        logic [2:0] out;
    } vec_t;

    // Model: a grant expands into the full expected output schedule of that run.
    vec_t q[$];
    vec_t exp_v;
    vec_t e;
    bit   m_valid = 1'b0;
    logic m_last;
    int   m_w, m_len;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            exp_v   = '0;
            m_last  = 1'b1;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (q.size() > 0) begin
                exp_v = q.pop_front();
            end else if (!exp_v.busy) begin
                m_w = -1;
                if (req0 && req1) m_w = m_last ? 0 : 1;
                else if (req0)    m_w = 0;
                else if (req1)    m_w = 1;
                if (m_w >= 0) begin
                    m_len = (m_w == 0) ? int'(len0) : int'(len1);
                    for (int k = 0; k <= m_len; k++) begin
                        e = '0; e.g0 = (m_w == 0); e.g1 = (m_w == 1);
                        e.busy = 1'b1; e.out = 3'(k);
                        q.push_back(e);
                    end
                    e = '0; e.d0 = (m_w == 0); e.d1 = (m_w == 1); e.busy = 1'b1;
                    q.push_back(e);
                    m_last = (m_w == 1);
                    exp_v  = q.pop_front();
                end else begin
                    exp_v = '0;
                end
            end else begin
                exp_v = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            vectors++;
            if ({gnt0, gnt1, done0, done1, busy, out} !== exp_v) begin
                miscompares++;
                $display("FAIL model_cycle t=%0t got {g0 g1 d0 d1 busy out}=%b expected %b",
                         $time, {gnt0, gnt1, done0, done1, busy, out}, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int   rises[$];
    int   who[$];
    logic p0, p1;
    int   exp_r[4];
    int   exp_w[4];

    initial begin
        rst = 1'b1; req0 = 1'b1; req1 = 1'b0; len0 = 3'd3; len1 = 3'd0;
        step(); step();
        chk("reset_outputs", {2'b00, gnt0, gnt1, done0, done1, busy, out}, 8'h00);
        rst = 1'b0;
        step();
        chk("first_grant", {gnt0, gnt1, busy, out}, {1'b1, 1'b0, 1'b1, 3'd0});
        req0 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("single_run_out", {gnt0, out}, {1'b1, 3'(k)});
        end
        step();
        chk("single_done", {gnt0, done0, busy, out}, {1'b0, 1'b1, 1'b1, 3'd0});
        step();
        chk("single_idle", {7'd0, busy}, 8'h00);

        // tie with both requests held from reset
        req0 = 1'b1; req1 = 1'b1; len0 = 3'd1; len1 = 3'd2; rst = 1'b1;
        step();
        rst = 1'b0; p0 = 1'b0; p1 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (gnt0 && !p0) begin rises.push_back(i); who.push_back(0); end
            if (gnt1 && !p1) begin rises.push_back(i); who.push_back(1); end
            if (gnt0 && gnt1) chk("gnt_exclusive", 8'd1, 8'd0);
            p0 = gnt0; p1 = gnt1;
        end
        req0 = 1'b0; req1 = 1'b0;
        exp_r = '{1, 5, 10, 14};
        exp_w = '{0, 1, 0, 1};
        chk("rr_grant_count", 8'(rises.size()), 8'd4);
        if (rises.size() == 4) begin
            for (int j = 0; j < 4; j++) begin
                chk("rr_grant_cycle", 8'(rises[j]), 8'(exp_r[j]));
                chk("rr_grant_owner", 8'(who[j]), 8'(exp_w[j]));
            end
        end
        step(); step(); step();

        // boundary lengths
        len1 = 3'd0; req1 = 1'b1;
        step();
        chk("len0_run", {gnt1, out}, {1'b1, 3'd0});
        req1 = 1'b0;
        step();
        chk("len0_done", {gnt1, done1}, 2'b01);
        step();
        len1 = 3'd7; req1 = 1'b1;
        step();
        chk("len7_start", {gnt1, out}, {1'b1, 3'd0});
        req1 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("len7_out", {gnt1, out}, {1'b1, 3'(k)});
        end
        step();
        chk("len7_done", {gnt1, done1, out}, {1'b0, 1'b1, 3'd0});
        step();

        // request dropped mid-run
        len0 = 3'd5; req0 = 1'b1;
        step();
        chk("drop_grant", {gnt0, out}, {1'b1, 3'd0});
        step(); step();
        chk("drop_at2", {gnt0, out}, {1'b1, 3'd2});
        req0 = 1'b0;
        step(); step(); step();
        chk("drop_reach5", {gnt0, out}, {1'b1, 3'd5});
        step();
        chk("drop_done", {gnt0, done0}, 2'b01);
        step();

        // reset mid-run
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        step(); step(); step();
        chk("abort_at3", {gnt0, out}, {1'b1, 3'd3});
        rst = 1'b1;
        step();
        chk("abort_reset", {gnt0, done0, busy, out}, {1'b0, 1'b0, 1'b0, 3'd0});
        rst = 1'b0;
        step();
        chk("abort_no_done", {done0, gnt0}, 2'b00);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
